vga_sync_gen: RTL



---
 rtl/vga_sync_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Timing master for a 640x480@60 VGA output path running on the board clock.
// A clock divider produces an internal pixel enable; the horizontal and
// vertical counters advance only on that enable. This keeps the whole design
// on a single clock domain. hc/vc count the full line/frame, including the
// sync pulse, so the visible area starts at (HBP, VBP).
//
// Optional feature (compile-time macro VGA_PIX_COORD_EN):
//   When defined, adds pix_x/pix_y, which are visible-area coordinates
//   relative to (HBP, VBP). They are forced to 0 outside the visible area.
//   When undefined, these ports and their logic are absent.
//
// Ports:
//   clk          in   board clock
//   clr          in   synchronous active-high reset
//   hsync        out  horizontal sync, active low (low while hc < HSYNC_W)
//   vsync        out  vertical sync, active low (low while vc < VSYNC_W)
//   hc           out  horizontal count, 0..HPIXELS-1
//   vc           out  vertical count, 0..VLINES-1
//   vidon        out  high while hc/vc lie inside the visible window
//   pix_en       out  one-clk pulse on each edge where the counters advance
//   frame_start  out  one-clk pulse when the counters wrap to (0,0)
//   pix_x/pix_y  out  (VGA_PIX_COORD_EN only) visible coordinates or 0
//
// All outputs are registered. hsync/vsync/vidon (and pix_x/pix_y) are decoded
// from the next-state counter values, so they always describe the hc/vc
// presented in the same cycle.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV = 2,    // board clocks per pixel, >= 1
  parameter int HPIXELS = 800,  // pixel periods per line
  parameter int VLINES  = 521,  // lines per frame
  parameter int HSYNC_W = 96,   // hsync low width (pixels)
  parameter int VSYNC_W = 2,    // vsync low width (lines)
  parameter int HBP     = 144,  // first visible hc
  parameter int HFP     = 784,  // first non-visible hc after active area
  parameter int VBP     = 31,   // first visible vc
  parameter int VFP     = 511   // first non-visible vc after active area
) (
  input  logic       clk,
  input  logic       clr,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       vidon,
  output logic       pix_en,
  output logic       frame_start
`ifdef VGA_PIX_COORD_EN
  ,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y
`endif
);

  // A one-bit divider is kept for CLK_DIV=1. It never leaves 0, so the
  // enable then fires on every clock.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(HPIXELS - 1);
  localparam logic [9:0]       V_LAST   = 10'(VLINES - 1);
  localparam logic [9:0]       H_SYNC   = 10'(HSYNC_W);
  localparam logic [9:0]       V_SYNC   = 10'(VSYNC_W);
  localparam logic [9:0]       H_VIS_LO = 10'(HBP);
  localparam logic [9:0]       H_VIS_HI = 10'(HFP);
  localparam logic [9:0]       V_VIS_LO = 10'(VBP);
  localparam logic [9:0]       V_VIS_HI = 10'(VFP);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hc_q, hc_d;
  logic [9:0]       vc_q, vc_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vidon_q, vidon_d;
  logic             pix_en_q, pix_en_d;
  logic             frame_start_q, frame_start_d;
  logic             pix_tick;
`ifdef VGA_PIX_COORD_EN
  logic [9:0]       pix_x_q, pix_x_d;
  logic [9:0]       pix_y_q, pix_y_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    pix_tick      = (div_q == DIV_LAST);
    div_d         = pix_tick ? '0 : div_q + DIV_W'(1);
    hc_d          = hc_q;
    vc_d          = vc_q;
    pix_en_d      = 1'b0;
    frame_start_d = 1'b0;

    if (pix_tick) begin
      pix_en_d      = 1'b1;
      frame_start_d = (hc_q == H_LAST) && (vc_q == V_LAST);
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end

    // The decode uses the next counter values, so the registered sync/vidon
    // lines up with the registered hc/vc. Between enables hc_d == hc_q, so
    // the decode holds.
    hsync_d = (hc_d >= H_SYNC);
    vsync_d = (vc_d >= V_SYNC);
    vidon_d = (hc_d >= H_VIS_LO) && (hc_d < H_VIS_HI) &&
              (vc_d >= V_VIS_LO) && (vc_d < V_VIS_HI);

`ifdef VGA_PIX_COORD_EN
    pix_x_d = vidon_d ? (hc_d - H_VIS_LO) : '0;
    pix_y_d = vidon_d ? (vc_d - V_VIS_LO) : '0;
`endif
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clr is sampled on the clock edge. A mid-frame clear therefore
    // restarts cleanly on the next edge, and no frame_start is produced.
    if (clr) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vidon_q       <= 1'b0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_PIX_COORD_EN
      pix_x_q       <= '0;
      pix_y_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the
      // pre-edge values regardless of statement order.
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vidon_q       <= vidon_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_PIX_COORD_EN
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign vidon       = vidon_q;
  assign pix_en      = pix_en_q;
  assign frame_start = frame_start_q;
`ifdef VGA_PIX_COORD_EN
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
`endif

endmodule
